// File: rtl/rr_stream_mux_4to1_pkg.sv
// Shared types and constants for the 4-to-1 round-robin stream multiplexer.
// Holds the channel count, the select width and the arbitration FSM state type.
package stream_mux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } mux_state_t;

    // Next round-robin start point; the 2-bit add wraps channel 3 back to 0.
    function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] id);
        return id + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_stream_mux_4to1_if.sv
// Bundle of the four input channels plus the merged output channel of the mux.
// slave is the multiplexer's view; master is the view of the surrounding sources and sink.
interface rr_stream_mux_4to1_if #(
    parameter int WIDTH = 8
);
    import stream_mux_pkg::*;

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_last;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

endinterface

// File: rtl/rr_stream_mux_4to1_arbiter.sv
// Combinational 4-way round-robin arbiter: grants the first requester at or above ptr,
// wrapping 3 -> 0. grant is one-hot or all-zero; gid is only meaningful when any=1.
module rr_arbiter4
    import stream_mux_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] gid,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant = '0;
        gid   = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = ptr + SEL_W'(k);
            if (!any && req[idx]) begin
                any = 1'b1;
                gid = idx;
            end
        end
        if (any) begin
            grant[gid] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_stream_mux_4to1.sv
// 4-to-1 valid/ready stream multiplexer with round-robin arbitration, optional packet
// lock and a registered output stage tagged with the source channel id.
module rr_stream_mux_4to1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit PKT_LOCK = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    rr_stream_mux_4to1_if.slave bus
);

    mux_state_t       state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] lock_id_q, lock_id_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    logic [N_CH-1:0]  arb_req;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] gid;
    logic             any;
    logic             can_load;
    logic             accept;
    logic             sel_last;
    logic             eff_last;
    logic [WIDTH-1:0] sel_data;

    // While locked only the owning channel may request; everyone else stalls.
    assign arb_req = (state_q == LOCK) ? (bus.in_valid & (N_CH'(1) << lock_id_q))
                                       : bus.in_valid;

    rr_arbiter4 u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .gid   (gid),
        .any   (any)
    );

    assign can_load = ~out_valid_q | bus.out_ready;
    assign accept   = any & can_load;
    // Gated by rst_n so no source believes a beat was taken while reset is held.
    assign bus.in_ready = grant & {N_CH{can_load & rst_n}};

    always_comb begin
        sel_data = '0;
        case (gid)
            2'd0:    sel_data = bus.in_data[0*WIDTH +: WIDTH];
            2'd1:    sel_data = bus.in_data[1*WIDTH +: WIDTH];
            2'd2:    sel_data = bus.in_data[2*WIDTH +: WIDTH];
            2'd3:    sel_data = bus.in_data[3*WIDTH +: WIDTH];
            default: sel_data = '0;
        endcase
    end

    assign sel_last = bus.in_last[gid];
    assign eff_last = PKT_LOCK ? sel_last : 1'b1;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_id_d   = lock_id_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_sel_d   = gid;
            if (eff_last) begin
                rr_ptr_d = ptr_next(gid);
            end
            if (PKT_LOCK) begin
                if (state_q == ARB && !sel_last) begin
                    state_d   = LOCK;
                    lock_id_d = gid;
                end else if (state_q == LOCK && sel_last) begin
                    state_d = ARB;
                end
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            lock_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_id_q   <= lock_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux_4to1.sv
// Scoreboard bench for rr_stream_mux_4to1: one instance without packet lock (index 0)
// and one with packet lock (index 1), fed by per-channel source queues.
`timescale 1ns/1ps
module tb_rr_stream_mux_4to1;

    localparam int W  = 8;
    localparam int NL = 0;
    localparam int LK = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_stream_mux_4to1_if #(.WIDTH(W)) bus_n ();
    rr_stream_mux_4to1_if #(.WIDTH(W)) bus_l ();

    rr_stream_mux_4to1 #(.WIDTH(W), .PKT_LOCK(1'b0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    rr_stream_mux_4to1 #(.WIDTH(W), .PKT_LOCK(1'b1)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    logic [3:0]     v    [2];
    logic [3:0]     lst  [2];
    logic [4*W-1:0] d    [2];
    logic           ordy [2];
    logic [3:0]     rdy  [2];
    logic           ov   [2];
    logic [W-1:0]   od   [2];
    logic           ol   [2];
    logic [1:0]     os   [2];

    assign bus_n.in_valid  = v[NL];
    assign bus_n.in_data   = d[NL];
    assign bus_n.in_last   = lst[NL];
    assign bus_n.out_ready = ordy[NL];
    assign bus_l.in_valid  = v[LK];
    assign bus_l.in_data   = d[LK];
    assign bus_l.in_last   = lst[LK];
    assign bus_l.out_ready = ordy[LK];

    assign rdy[NL] = bus_n.in_ready;
    assign ov[NL]  = bus_n.out_valid;
    assign od[NL]  = bus_n.out_data;
    assign ol[NL]  = bus_n.out_last;
    assign os[NL]  = bus_n.out_sel;
    assign rdy[LK] = bus_l.in_ready;
    assign ov[LK]  = bus_l.out_valid;
    assign od[LK]  = bus_l.out_data;
    assign ol[LK]  = bus_l.out_last;
    assign os[LK]  = bus_l.out_sel;

    logic [W:0]  sq [8][$];   // source beats {last, data}, index dut*4+channel
    logic [10:0] eq [2][$];   // expected output {sel, last, data}
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic src_push(input int u, input int ch, input int last, input int data);
        sq[u*4+ch].push_back({1'(last), W'(data)});
    endtask

    task automatic exp_push(input int u, input int sel, input int last, input int data);
        eq[u].push_back({2'(sel), 1'(last), W'(data)});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((eq[0].size() + eq[1].size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(eq[0].size() + eq[1].size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Source driver: retire beats that handshook at the last edge, present the next ones.
    initial begin : driver
        logic fire [8];
        for (int u = 0; u < 2; u++) begin
            v[u]   = '0;
            lst[u] = '0;
            d[u]   = '0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) fire[k] = v[k/4][k%4] & rdy[k/4][k%4];
            @(posedge clk);
            #2;
            for (int k = 0; k < 8; k++) begin
                if (fire[k] && sq[k].size() != 0) void'(sq[k].pop_front());
                if (sq[k].size() != 0) begin
                    v[k/4][k%4]           = 1'b1;
                    lst[k/4][k%4]         = sq[k][0][W];
                    d[k/4][(k%4)*W +: W]  = sq[k][0][W-1:0];
                end else begin
                    v[k/4][k%4] = 1'b0;
                end
            end
        end
    end

    // Output monitor: every beat that will transfer at the next edge is checked in order.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                if (ov[u] && ordy[u]) begin
                    if (eq[u].size() == 0) begin
                        check($sformatf("sb%0d_extra", u), 32'({os[u], ol[u], od[u]}), 32'hFFFF_FFFF);
                    end else begin
                        check($sformatf("sb%0d_beat", u), 32'({os[u], ol[u], od[u]}), 32'(eq[u].pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        ordy[NL] = 1'b1;
        ordy[LK] = 1'b1;

        // Reset with every channel valid, then ch0 wins first.
        for (int ch = 0; ch < 4; ch++) begin
            src_push(LK, ch, 1, 'hB0 + ch);
            exp_push(LK, ch, 1, 'hB0 + ch);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ov[LK]), 0);
        check("rst_out_sel", 32'(os[LK]), 0);
        check("rst_out_data", 32'(od[LK]), 0);
        check("rst_in_ready", 32'(rdy[LK]), 0);
        check("rst_nl_out_valid", 32'(ov[NL]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_first_grant", 32'(rdy[LK]), 1);
        drain("t1");

        // No lock: four single beats on consecutive cycles.
        for (int ch = 0; ch < 4; ch++) begin
            src_push(NL, ch, 1, 'hA0 + ch);
            exp_push(NL, ch, 1, 'hA0 + ch);
        end
        @(negedge clk);
        check("t2_first_grant", 32'(rdy[NL]), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t2_valid_%0d", i), 32'(ov[NL]), 1);
            check($sformatf("t2_sel_%0d", i), 32'(os[NL]), 32'(i));
            check($sformatf("t2_data_%0d", i), 32'(od[NL]), 32'('hA0 + i));
        end
        drain("t2");

        // No lock: a non-last beat still releases the grant; last passes through.
        src_push(NL, 0, 0, 'hC0);
        src_push(NL, 0, 1, 'hC1);
        src_push(NL, 1, 1, 'hD0);
        exp_push(NL, 0, 0, 'hC0);
        exp_push(NL, 1, 1, 'hD0);
        exp_push(NL, 0, 1, 'hC1);
        drain("t2b");

        // Lock: ch1 3-beat packet with a bubble, ch2 waits throughout.
        src_push(LK, 1, 0, 'h11);
        src_push(LK, 1, 0, 'h12);
        src_push(LK, 2, 1, 'h21);
        exp_push(LK, 1, 0, 'h11);
        exp_push(LK, 1, 0, 'h12);
        exp_push(LK, 1, 1, 'h13);
        exp_push(LK, 2, 1, 'h21);
        @(negedge clk);
        check("t3_rdy_b1", 32'(rdy[LK]), 2);
        @(negedge clk);
        check("t3_rdy_b2", 32'(rdy[LK]), 2);
        @(negedge clk);
        check("t3_rdy_bubble_a", 32'(rdy[LK]), 0);
        @(negedge clk);
        check("t3_rdy_bubble_b", 32'(rdy[LK]), 0);
        @(posedge clk);
        #1;
        src_push(LK, 1, 1, 'h13);
        @(negedge clk);
        check("t3_rdy_b3", 32'(rdy[LK]), 2);
        @(negedge clk);
        check("t3_rdy_ch2", 32'(rdy[LK]), 4);
        drain("t3");

        // Wrap: pointer at 3, ch3 then ch0, then pointer sits at 1.
        src_push(LK, 0, 1, 'h30);
        src_push(LK, 3, 1, 'h33);
        exp_push(LK, 3, 1, 'h33);
        exp_push(LK, 0, 1, 'h30);
        @(negedge clk);
        check("t5_rdy_ch3", 32'(rdy[LK]), 8);
        drain("t5");
        for (int ch = 0; ch < 4; ch++) src_push(LK, ch, 1, 'h40 + ch);
        exp_push(LK, 1, 1, 'h41);
        exp_push(LK, 2, 1, 'h42);
        exp_push(LK, 3, 1, 'h43);
        exp_push(LK, 0, 1, 'h40);
        @(negedge clk);
        check("t5_rdy_ptr1", 32'(rdy[LK]), 2);
        drain("t5b");

        // Backpressure: 0x55 held for 5 cycles, then 0x56 follows with no bubble.
        ordy[LK] = 1'b0;
        src_push(LK, 1, 1, 'h55);
        src_push(LK, 2, 1, 'h56);
        exp_push(LK, 1, 1, 'h55);
        exp_push(LK, 2, 1, 'h56);
        @(negedge clk);
        check("t4_rdy_load", 32'(rdy[LK]), 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold_valid_%0d", i), 32'(ov[LK]), 1);
            check($sformatf("t4_hold_data_%0d", i), 32'(od[LK]), 'h55);
            check($sformatf("t4_hold_rdy_%0d", i), 32'(rdy[LK]), 0);
        end
        @(posedge clk);
        #1;
        ordy[LK] = 1'b1;
        @(negedge clk);
        check("t4_rdy_release", 32'(rdy[LK]), 4);
        @(negedge clk);
        check("t4_next_valid", 32'(ov[LK]), 1);
        check("t4_next_data", 32'(od[LK]), 'h56);
        drain("t4");

        // Reset during the 2nd beat of a locked ch2 packet.
        src_push(LK, 2, 0, 'h61);
        src_push(LK, 2, 0, 'h62);
        src_push(LK, 2, 1, 'h63);
        exp_push(LK, 2, 0, 'h61);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_beat2_out", 32'(od[LK]), 'h62);
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) sq[k].delete();
        #1;
        check("t6_async_valid", 32'(ov[LK]), 0);
        check("t6_async_rdy", 32'(rdy[LK]), 0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_data", 32'(od[LK]), 0);
        rst_n = 1'b1;
        src_push(LK, 0, 1, 'h70);
        src_push(LK, 2, 1, 'h72);
        exp_push(LK, 0, 1, 'h70);
        exp_push(LK, 2, 1, 'h72);
        @(negedge clk);
        check("t6_ch0_wins", 32'(rdy[LK]), 1);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
